// File: rtl/cdc_arb_pkg.sv
// Shared types and elaboration helpers for the synchronizer source-side arbiter.
package cdc_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } arb_state_t;

    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v = value - 1;
        while (v > 0) begin
            result = result + 1;
            v = v >> 1;
        end
        return result;
    endfunction

    // GUARD=1 would give a zero-width counter, so floor the width at one bit.
    function automatic int guard_width(input int guard);
        return (clog2(guard) < 1) ? 1 : clog2(guard);
    endfunction

endpackage

// File: rtl/cdc_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping.
module cdc_rr_pick
    import cdc_arb_pkg::*;
#(
    parameter int N_REQ = 4
) (
    input  logic [N_REQ-1:0]        req,
    input  logic [clog2(N_REQ)-1:0] ptr,
    output logic                    valid,
    output logic [clog2(N_REQ)-1:0] idx
);

    localparam int IW = clog2(N_REQ);

    // Scan requesters starting at the pointer; the first hit wins.
    always_comb begin
        logic [IW-1:0] pos;
        valid = 1'b0;
        idx   = '0;
        pos   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            pos = IW'((int'(ptr) + k) % N_REQ);
            if (!valid && req[pos]) begin
                valid = 1'b1;
                idx   = pos;
            end else begin
                valid = valid;
                idx   = idx;
            end
        end
    end

endmodule

// File: rtl/cdc_tx_arbiter.sv
// Source-domain controller sharing one flag/data synchronizer among N_REQ requesters:
// round-robin grant, one-cycle flag, then data held for GUARD cycles (longer while busy).
module cdc_tx_arbiter
    import cdc_arb_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int DW    = 8,
    parameter int GUARD = 96
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [N_REQ-1:0]        req,
    input  logic [N_REQ*DW-1:0]     req_data,
    output logic [N_REQ-1:0]        ack,
    output logic                    cdc_flag,
    output logic [DW-1:0]           cdc_data,
    input  logic                    cdc_busy,
    output logic [clog2(N_REQ)-1:0] grant_id,
    output logic                    idle
);

    localparam int IW = clog2(N_REQ);
    localparam int CW = guard_width(GUARD);
    localparam logic [CW-1:0] GUARD_LOAD = CW'(GUARD - 1);
    localparam logic [IW-1:0] LAST_IDX   = IW'(N_REQ - 1);

    arb_state_t       state_r, state_s;
    logic [CW-1:0]    cnt_r, cnt_s;
    logic [IW-1:0]    ptr_r, ptr_s;
    logic             flag_r, flag_s;
    logic [N_REQ-1:0] ack_r, ack_s;
    logic [DW-1:0]    data_r, data_s;
    logic [IW-1:0]    gid_r, gid_s;
    logic             idle_r, idle_s;

    logic             pick_valid_s;
    logic [IW-1:0]    pick_idx_s;
    logic [DW-1:0]    pick_data_s;

    cdc_rr_pick #(
        .N_REQ(N_REQ)
    ) u_pick (
        .req  (req),
        .ptr  (ptr_r),
        .valid(pick_valid_s),
        .idx  (pick_idx_s)
    );

    // Select the data lane of the winning requester.
    always_comb begin
        pick_data_s = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (pick_idx_s == IW'(i)) begin
                pick_data_s = req_data[i*DW +: DW];
            end else begin
                pick_data_s = pick_data_s;
            end
        end
    end

    // Next-state and next-output logic; flag and ack default low so they pulse once.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        ptr_s   = ptr_r;
        flag_s  = 1'b0;
        ack_s   = '0;
        data_s  = data_r;
        gid_s   = gid_r;
        case (state_r)
            IDLE: begin
                if (pick_valid_s) begin
                    state_s = HOLD;
                    cnt_s   = GUARD_LOAD;
                    ptr_s   = (pick_idx_s == LAST_IDX) ? '0 : pick_idx_s + IW'(1);
                    flag_s  = 1'b1;
                    ack_s   = {{(N_REQ-1){1'b0}}, 1'b1} << pick_idx_s;
                    data_s  = pick_data_s;
                    gid_s   = pick_idx_s;
                end else begin
                    state_s = IDLE;
                end
            end
            HOLD: begin
                // Counter saturates at zero; busy stretches the hold cycle-for-cycle.
                if (cnt_r == {CW{1'b0}}) begin
                    if (!cdc_busy) begin
                        state_s = IDLE;
                    end else begin
                        state_s = HOLD;
                    end
                end else begin
                    cnt_s = cnt_r - CW'(1);
                end
            end
            default: begin
                state_s = IDLE;
                cnt_s   = '0;
            end
        endcase
        idle_s = (state_s == IDLE);
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            cnt_r   <= '0;
            ptr_r   <= '0;
            flag_r  <= 1'b0;
            ack_r   <= '0;
            data_r  <= '0;
            gid_r   <= '0;
            idle_r  <= 1'b1;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            ptr_r   <= ptr_s;
            flag_r  <= flag_s;
            ack_r   <= ack_s;
            data_r  <= data_s;
            gid_r   <= gid_s;
            idle_r  <= idle_s;
        end
    end

    assign ack      = ack_r;
    assign cdc_flag = flag_r;
    assign cdc_data = data_r;
    assign grant_id = gid_r;
    assign idle     = idle_r;

endmodule

// File: tb/tb_cdc_tx_arbiter.sv
// Self-checking bench for cdc_tx_arbiter: grant table, directed multi-cycle cases,
// a behavioural destination domain, and randomized traffic against a reference model.
module tb_cdc_tx_arbiter;

    localparam int N_REQ = 4;
    localparam int DW    = 8;
    localparam int GUARD = 96;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [N_REQ-1:0] req = '0;
    logic [N_REQ*DW-1:0] req_data = '0;
    logic [N_REQ-1:0] ack;
    logic             cdc_flag;
    logic [DW-1:0]    cdc_data;
    logic             cdc_busy = 1'b0;
    logic [1:0]       grant_id;
    logic             idle;

    int n_checks = 0;
    int n_pass   = 0;

    always #20 clk = ~clk;

    cdc_tx_arbiter #(.N_REQ(N_REQ), .DW(DW), .GUARD(GUARD)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .req_data(req_data), .ack(ack),
        .cdc_flag(cdc_flag), .cdc_data(cdc_data), .cdc_busy(cdc_busy),
        .grant_id(grant_id), .idle(idle)
    );

    // Behavioural destination: toggle handshake into a ~29x slower clock.
    logic       dclk = 1'b0;
    logic       tog = 1'b0, s1 = 1'b0, s2 = 1'b0, s3 = 1'b0;
    logic [7:0] dq[$];
    always #571 dclk = ~dclk;
    always @(posedge clk) if (cdc_flag) tog <= ~tog;
    always @(posedge dclk) begin
        s1 <= tog;
        s2 <= s1;
        s3 <= s2;
        if (s2 != s3) dq.push_back(cdc_data);
    end

    typedef struct {
        logic [3:0] prime;
        logic [3:0] rq;
        logic       exp_flag;
        logic [1:0] exp_gid;
    } vec_t;
    vec_t vecs[10];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        req = '0;
        cdc_busy = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic wait_flag(input string name, input int max, output int cyc);
        bit ok;
        ok = 1'b0;
        cyc = 0;
        while (cyc < max && !ok) begin
            tick();
            cyc++;
            if (cdc_flag) ok = 1'b1;
        end
        check({name, "_flag_seen"}, 64'(ok), 64'(1));
    endtask

    // Reference model state: abstract "cycles since grant" rather than a down-counter.
    bit         m_idle;
    int         m_ptr, m_since;
    bit         m_flag;
    logic [3:0] m_ack;
    logic [7:0] m_data;
    logic [1:0] m_gid;

    task automatic model_edge();
        int g;
        m_flag = 1'b0;
        m_ack  = '0;
        if (m_idle) begin
            if (req != 0) begin
                g = -1;
                for (int k = 0; k < N_REQ; k++) begin
                    if (g < 0 && req[(m_ptr + k) % N_REQ]) g = (m_ptr + k) % N_REQ;
                end
                m_flag  = 1'b1;
                m_ack   = 4'(1 << g);
                m_data  = req_data[g*DW +: DW];
                m_gid   = 2'(g);
                m_ptr   = (g + 1) % N_REQ;
                m_idle  = 1'b0;
                m_since = 0;
            end
        end else begin
            m_since++;
            if (m_since >= GUARD && !cdc_busy) m_idle = 1'b1;
        end
    endtask

    initial begin
        int cyc, bad_pulse, bad_data, k;
        logic pre_idle;

        vecs[0] = '{4'b0000, 4'b0001, 1'b1, 2'd0};
        vecs[1] = '{4'b0000, 4'b0110, 1'b1, 2'd1};
        vecs[2] = '{4'b0000, 4'b1000, 1'b1, 2'd3};
        vecs[3] = '{4'b0000, 4'b1111, 1'b1, 2'd0};
        vecs[4] = '{4'b0000, 4'b0000, 1'b0, 2'd0};
        vecs[5] = '{4'b0001, 4'b0001, 1'b1, 2'd0};
        vecs[6] = '{4'b0010, 4'b0011, 1'b1, 2'd0};
        vecs[7] = '{4'b0100, 4'b1001, 1'b1, 2'd3};
        vecs[8] = '{4'b1000, 4'b1010, 1'b1, 2'd1};
        vecs[9] = '{4'b0010, 4'b1110, 1'b1, 2'd2};

        // Reset state.
        do_reset();
        check("reset_outputs", {cdc_flag, ack, cdc_data, grant_id, idle},
              {1'b0, 4'b0000, 8'h00, 2'd0, 1'b1});

        // Grant table: optional priming grant moves the pointer, then one request edge.
        req_data = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
        for (int v = 0; v < 10; v++) begin
            do_reset();
            if (vecs[v].prime != 4'b0000) begin
                req = vecs[v].prime;
                tick();
                req = '0;
                repeat (GUARD) tick();
            end
            req = vecs[v].rq;
            tick();
            check($sformatf("vec%0d", v), {cdc_flag, ack, cdc_data, grant_id},
                  {vecs[v].exp_flag,
                   vecs[v].exp_flag ? 4'(4'b0001 << vecs[v].exp_gid) : 4'b0000,
                   vecs[v].exp_flag ? 8'(8'hA0 + vecs[v].exp_gid) : 8'h00,
                   vecs[v].exp_gid});
            req = '0;
        end

        // Single request: one-cycle pulse, data held 97 cycles, idle returns.
        do_reset();
        req_data = {8'h00, 8'h00, 8'h00, 8'h42};
        req = 4'b0001;
        tick();
        check("single_first", {cdc_flag, ack, cdc_data, idle}, {1'b1, 4'b0001, 8'h42, 1'b0});
        req = '0;
        bad_pulse = 0;
        bad_data = 0;
        pre_idle = 1'b0;
        for (int i = 1; i <= GUARD; i++) begin
            tick();
            if (cdc_flag || ack != 4'b0000) bad_pulse++;
            if (cdc_data != 8'h42) bad_data++;
            if (i == GUARD - 1) pre_idle = idle;
        end
        check("single_pulse_once", 64'(bad_pulse), 64'(0));
        check("single_data_hold", 64'(bad_data), 64'(0));
        check("single_idle_early", 64'(pre_idle), 64'(0));
        check("single_idle_back", 64'(idle), 64'(1));

        // Contention: requester 0 first, requester 2 exactly 97 cycles later.
        do_reset();
        req_data = {8'h00, 8'h22, 8'h00, 8'h11};
        req = 4'b0101;
        tick();
        check("cont_first", {ack, cdc_data, grant_id}, {4'b0001, 8'h11, 2'd0});
        req = 4'b0100;
        wait_flag("cont", 200, cyc);
        check("cont_second", {ack, cdc_data, grant_id, 8'(cyc)}, {4'b0100, 8'h22, 2'd2, 8'd97});
        req = '0;

        // Fairness: all requesters held continuously.
        do_reset();
        req_data = {8'h33, 8'h22, 8'h11, 8'h00};
        req = 4'b1111;
        tick();
        check("fair_0", {cdc_flag, grant_id}, {1'b1, 2'd0});
        for (int i = 1; i <= 5; i++) begin
            wait_flag($sformatf("fair_%0d", i), 200, cyc);
            check($sformatf("fair_%0d", i), {grant_id, 8'(cyc), cdc_data},
                  {2'(i % 4), 8'd97, 8'(8'h11 * (i % 4))});
        end
        req = '0;

        // Busy stretch: busy held through 20 cycles past guard expiry.
        do_reset();
        req_data = {8'h00, 8'h00, 8'h5B, 8'h5A};
        req = 4'b0011;
        tick();
        check("busy_first", {cdc_flag, grant_id}, {1'b1, 2'd0});
        req = 4'b0010;
        cdc_busy = 1'b1;
        k = 0;
        while (k < 200 && !(k > 0 && cdc_flag)) begin
            tick();
            k++;
            if (k == 115) cdc_busy = 1'b0;
        end
        check("busy_spacing", {8'(k), grant_id, cdc_data}, {8'd117, 2'd1, 8'h5B});
        req = '0;
        cdc_busy = 1'b0;

        // Reset mid-HOLD clears outputs immediately and the pointer.
        do_reset();
        req_data = {8'hD3, 8'hD2, 8'hD1, 8'hD0};
        req = 4'b0100;
        tick();
        check("rst_grant", grant_id, 2'd2);
        req = 4'b1001;
        repeat (50) tick();
        rst_n = 1'b0;
        #1;
        check("rst_async", {cdc_flag, ack, cdc_data, grant_id, idle},
              {1'b0, 4'b0000, 8'h00, 2'd0, 1'b1});
        tick();
        rst_n = 1'b1;
        tick();
        check("rst_release", {cdc_flag, ack, grant_id, cdc_data}, {1'b1, 4'b0001, 2'd0, 8'hD0});
        req = 4'b1000;
        wait_flag("rst_next", 200, cyc);
        check("rst_req3", {grant_id, 8'(cyc), cdc_data}, {2'd3, 8'd97, 8'hD3});
        req = '0;

        // End-to-end through the behavioural destination domain.
        do_reset();
        repeat (150) tick();
        dq.delete();
        req_data = {8'd0, 8'd0, 8'd120, 8'd66};
        req = 4'b0001;
        tick();
        req = 4'b0010;
        wait_flag("e2e", 200, cyc);
        req = '0;
        repeat (300) tick();
        check("e2e_count", 64'(dq.size()), 64'(2));
        if (dq.size() == 2) begin
            check("e2e_word0", dq[0], 8'd66);
            check("e2e_word1", dq[1], 8'd120);
        end

        // Randomized traffic against the reference model.
        do_reset();
        m_idle = 1'b1;
        m_ptr = 0;
        m_since = 0;
        m_flag = 1'b0;
        m_ack = '0;
        m_data = '0;
        m_gid = '0;
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N_REQ; i++) req[i] = ($urandom_range(0, 5) == 0);
            req_data = {$urandom()};
            cdc_busy = ($urandom_range(0, 2) == 0);
            @(posedge clk);
            model_edge();
            @(negedge clk);
            check($sformatf("rand_c%0d", c), {cdc_flag, ack, cdc_data, grant_id, idle},
                  {m_flag, m_ack, m_data, m_gid, m_idle});
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/cdc_tx_arbiter.md
Name: cdc_tx_arbiter

Overview:
Source-domain controller for the flag/data word synchronizer. It shares one synchronizer channel between N_REQ requesters and arbitrates among them round-robin. For each granted word it issues a single-cycle flag pulse, then holds the data bus stable until the destination domain has had time to capture it. It also enforces the minimum flag spacing the synchronizer needs, since the destination clock is about 29x slower.

Parameters:
N_REQ, 4, number of requesters (2..8)
DW, 8, data word width
GUARD, 96, minimum clk cycles to hold cdc_data after a flag; must be >=1 and >= 3 destination periods in clk cycles

Ports:
clk  in  1  source-domain clock
rst_n  in  1  asynchronous active-low reset
req  in  N_REQ  per-requester transfer request, level
req_data  in  N_REQ*DW  requester i data at bits [i*DW +: DW]
ack  out  N_REQ  one-cycle pulse: requester's word accepted
cdc_flag  out  1  one-cycle pulse to synchronizer flag input
cdc_data  out  DW  word to synchronizer data input, held stable during HOLD
cdc_busy  in  1  optional level from the synchronizer, already resynchronized into clk; tie 0 if unused
grant_id  out  clog2(N_REQ)  index of the last granted requester
idle  out  1  high when in IDLE

Behaviour:
- Reset (async assert, sync release) sets:
  - cdc_flag=0, cdc_data=0, ack=0, grant_id=0, idle=1.
  - State IDLE, guard counter 0, round-robin pointer 0 (requester 0 highest priority).
- IDLE:
  - If req!=0 at an edge, pick the first set bit at or above the pointer, wrapping modulo N_REQ.
  - At that same edge, register cdc_data=req_data[g], cdc_flag=1, ack[g]=1, grant_id=g.
  - Also set pointer=(g+1) mod N_REQ, counter=GUARD-1, and go to HOLD.
  - Latency: the flag is high in the cycle directly after the edge where req was sampled.
- HOLD:
  - cdc_flag and ack return to 0 at the next edge.
  - cdc_data is held unchanged.
  - The counter decrements to 0 and saturates there.
  - At the edge where counter==0 and cdc_busy==0, go to IDLE.
  - cdc_data keeps its value in IDLE; it is not cleared.
- Flag spacing:
  - Consecutive flags are at least GUARD+1 cycles apart; with cdc_busy=0 they are exactly GUARD+1 apart.
  - If cdc_busy is high when the counter reaches 0, HOLD extends cycle-for-cycle until busy falls.
- Requester protocol:
  - Hold req high with stable req_data until ack.
  - req may fall in the cycle after ack.
  - req still high after ack is a new request, serviced in turn.
  - If req falls before ack, nothing is transferred.
  - req and req_data changes during HOLD have no effect on cdc_data.
- Simultaneous events:
  - Multiple requests: resolved by round-robin, one grant per issue.
  - A request arriving in the same cycle as the HOLD->IDLE transition is seen at the next IDLE edge.
- Reset mid-HOLD:
  - Outputs clear immediately.
  - The downstream may see a truncated data-hold window; the system resets both domains together.
- idle = (state==IDLE), registered.

Decomposition:
- Package cdc_arb_pkg:
  - state enum {IDLE, HOLD};
  - clog2 constant function;
  - GUARD width = clog2(GUARD).
- Sub-module cdc_rr_pick: combinational round-robin priority encoder (inputs req and ptr; outputs valid and idx). It is instantiated once.

Test Plan (N_REQ=4, DW=8, GUARD=96, clk period 40 ns):
1. Single request: req[0]=1, data 8'h42 -> next cycle cdc_flag=1 and ack[0]=1 for exactly 1 cycle; cdc_data=8'h42 stable for 97 cycles; idle returns to 1.
2. Contention: req[0]=8'h11 and req[2]=8'h22 in the same cycle, pointer=0 -> 8'h11 is flagged first; the 8'h22 flag follows exactly 97 cycles later with ack[2].
3. Fairness: all four req held high continuously -> grant_id sequence is 0,1,2,3,0,1 with flags 97 cycles apart and no requester skipped.
4. Busy stretch: cdc_busy held high for 20 cycles after the guard expires -> the next flag is 117 cycles after the previous one.
5. Reset mid-HOLD: assert rst_n=0 at guard count 50 -> cdc_flag, cdc_data, ack clear asynchronously and the pointer resets to 0. After release, pending req[3] is flagged one cycle later.
6. End-to-end with the synchronizer (destination clock period 1142 ns): send 8'd66, then 8'd120 from two requesters -> destination flag pulses twice, and the destination data reads 66 then 120 with no loss.
